// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared constants, drain FSM states and helpers for the issue stage
package segre_pkg;

  localparam int REG_SIZE       = 5;
  localparam int M_EXT_LATENCY  = 5;
  localparam int ALU_WB_LATENCY = 3;

  typedef enum logic [1:0] {
    M_RUN     = 2'd0,
    M_DRAIN   = 2'd1,
    M_DRAINED = 2'd2
  } m_drain_state_e;

  // Number of set bits in a slot-valid vector (up to seven slots).
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/m_ext_scoreboard.sv
// rtl/m_ext_scoreboard.sv - shift scoreboard of in-flight M ops with RAW/WAW and writeback-port hazard checks
module m_ext_scoreboard
  import segre_pkg::*;
#(
  parameter int M_LAT   = M_EXT_LATENCY,
  parameter int WB_SLOT = M_EXT_LATENCY - ALU_WB_LATENCY
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                load_i,
  input  logic                load_we_i,
  input  logic [REG_SIZE-1:0] load_rd_i,
  input  logic                chk_valid_i,
  input  logic                chk_is_m_i,
  input  logic                chk_we_i,
  input  logic [REG_SIZE-1:0] chk_rs1_i,
  input  logic [REG_SIZE-1:0] chk_rs2_i,
  input  logic [REG_SIZE-1:0] chk_rd_i,
  output logic                raw_hazard_o,
  output logic                wb_hazard_o,
  output logic                wb_sel_o,
  output logic [M_LAT-1:0]    valid_o
);

  // Slot k holds the M op accepted k cycles ago; slot M_LAT is the writeback cycle.
  logic [M_LAT:1]      slot_valid;
  logic [M_LAT:1]      slot_we;
  logic [REG_SIZE-1:0] slot_rd [1:M_LAT];
  logic                raw_any;

  // Shift every cycle; a non-M or stalled cycle inserts an empty bubble in slot 1.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      slot_valid <= '0;
      slot_we    <= '0;
      for (int k = 1; k <= M_LAT; k++) begin
        slot_rd[k] <= '0;
      end
    end else begin
      slot_valid[1] <= load_i;
      slot_we[1]    <= load_i & load_we_i;
      slot_rd[1]    <= load_rd_i;
      for (int k = 2; k <= M_LAT; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_we[k]    <= slot_we[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end
    end
  end

  // Source reads and non-M destination writes collide with any pending M result; x0 never collides.
  always_comb begin
    raw_any = 1'b0;
    for (int k = 1; k <= M_LAT; k++) begin
      if (slot_valid[k] && slot_we[k]) begin
        if ((chk_rs1_i != '0) && (chk_rs1_i == slot_rd[k])) raw_any = 1'b1;
        if ((chk_rs2_i != '0) && (chk_rs2_i == slot_rd[k])) raw_any = 1'b1;
        if (!chk_is_m_i && chk_we_i && (chk_rd_i != '0) && (chk_rd_i == slot_rd[k])) raw_any = 1'b1;
      end
    end
  end

  assign raw_hazard_o = chk_valid_i & raw_any;
  // A non-M write issued now would reach the regfile port in the same cycle as the op in WB_SLOT.
  assign wb_hazard_o  = chk_valid_i & ~chk_is_m_i & chk_we_i & slot_valid[WB_SLOT] & slot_we[WB_SLOT];
  assign wb_sel_o     = slot_valid[M_LAT] & slot_we[M_LAT];
  assign valid_o      = slot_valid;

endmodule

// File: rtl/m_ext_issue_ctrl.sv
// rtl/m_ext_issue_ctrl.sv - issue gating for the M-extension pipeline with drain handshake
module m_ext_issue_ctrl
  import segre_pkg::*;
#(
  parameter int M_LAT      = M_EXT_LATENCY,
  parameter int ALU_WB_LAT = ALU_WB_LATENCY
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                issue_valid_i,
  input  logic                issue_is_m_i,
  input  logic                issue_rf_we_i,
  input  logic [REG_SIZE-1:0] issue_rs1_i,
  input  logic [REG_SIZE-1:0] issue_rs2_i,
  input  logic [REG_SIZE-1:0] issue_rd_i,
  output logic                issue_ready_o,
  output logic                m_valid_o,
  output logic                wb_sel_m_o,
  output logic [2:0]          inflight_cnt_o,
  output logic                stall_raw_o,
  output logic                stall_wb_o,
  input  logic                drain_req_i,
  output logic                drain_ack_o
);

  m_drain_state_e     state_q;
  m_drain_state_e     state_d;
  logic [M_LAT-1:0]   slot_valid;
  logic [6:0]         valid_ext;

  m_ext_scoreboard #(
    .M_LAT   (M_LAT),
    .WB_SLOT (M_LAT - ALU_WB_LAT)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .load_i       (m_valid_o),
    .load_we_i    (issue_rf_we_i),
    .load_rd_i    (issue_rd_i),
    .chk_valid_i  (issue_valid_i),
    .chk_is_m_i   (issue_is_m_i),
    .chk_we_i     (issue_rf_we_i),
    .chk_rs1_i    (issue_rs1_i),
    .chk_rs2_i    (issue_rs2_i),
    .chk_rd_i     (issue_rd_i),
    .raw_hazard_o (stall_raw_o),
    .wb_hazard_o  (stall_wb_o),
    .wb_sel_o     (wb_sel_m_o),
    .valid_o      (slot_valid)
  );

  // Widen the slot-valid vector to the fixed popcount width.
  always_comb begin
    valid_ext = '0;
    valid_ext[M_LAT-1:0] = slot_valid;
  end

  assign inflight_cnt_o = popcount7(valid_ext);
  assign issue_ready_o  = ~stall_raw_o & ~stall_wb_o & (state_q == M_RUN);
  assign m_valid_o      = issue_valid_i & issue_ready_o & issue_is_m_i;
  assign drain_ack_o    = (state_q == M_DRAINED);

  // Drain sequencing: block issue, wait for the pipeline to empty, hold until the request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      M_RUN: begin
        if (drain_req_i) state_d = (inflight_cnt_o == 3'd0) ? M_DRAINED : M_DRAIN;
      end
      M_DRAIN: begin
        if (inflight_cnt_o == 3'd0) state_d = M_DRAINED;
      end
      M_DRAINED: begin
        if (!drain_req_i) state_d = M_RUN;
      end
      default: state_d = M_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state_q <= M_RUN;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_m_ext_issue_ctrl.sv
// tb/tb_m_ext_issue_ctrl.sv - directed scoreboard bench for m_ext_issue_ctrl
module tb_m_ext_issue_ctrl;

  logic       clk_i = 1'b0;
  logic       rsn_i;
  logic       issue_valid_i, issue_is_m_i, issue_rf_we_i;
  logic [4:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic       issue_ready_o, m_valid_o, wb_sel_m_o, stall_raw_o, stall_wb_o;
  logic [2:0] inflight_cnt_o;
  logic       drain_req_i, drain_ack_o;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  typedef struct {
    logic       rdy;
    logic       mv;
    logic       raw;
    logic       wb;
    logic       sel;
    logic [2:0] cnt;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];

  m_ext_issue_ctrl dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .issue_valid_i  (issue_valid_i),
    .issue_is_m_i   (issue_is_m_i),
    .issue_rf_we_i  (issue_rf_we_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_rs2_i    (issue_rs2_i),
    .issue_rd_i     (issue_rd_i),
    .issue_ready_o  (issue_ready_o),
    .m_valid_o      (m_valid_o),
    .wb_sel_m_o     (wb_sel_m_o),
    .inflight_cnt_o (inflight_cnt_o),
    .stall_raw_o    (stall_raw_o),
    .stall_wb_o     (stall_wb_o),
    .drain_req_i    (drain_req_i),
    .drain_ack_o    (drain_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step%0d observed=%0d expected=%0d", tag, step, obs, exp);
    end
  endtask

  // One cycle: drive inputs, queue the expected outputs, compare them mid-cycle.
  task automatic cyc(input logic v, input logic m, input logic we,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic drn,
                     input logic e_rdy, input logic e_mv, input logic e_raw, input logic e_wb,
                     input logic e_sel, input logic [2:0] e_cnt, input logic e_ack);
    exp_t e;
    exp_t g;
    issue_valid_i = v;
    issue_is_m_i  = m;
    issue_rf_we_i = we;
    issue_rs1_i   = rs1;
    issue_rs2_i   = rs2;
    issue_rd_i    = rd;
    drain_req_i   = drn;
    e.rdy = e_rdy; e.mv = e_mv; e.raw = e_raw; e.wb = e_wb;
    e.sel = e_sel; e.cnt = e_cnt; e.ack = e_ack;
    exp_q.push_back(e);
    @(negedge clk_i);
    g = exp_q.pop_front();
    check("issue_ready", {7'd0, issue_ready_o}, {7'd0, g.rdy});
    check("m_valid",     {7'd0, m_valid_o},     {7'd0, g.mv});
    check("stall_raw",   {7'd0, stall_raw_o},   {7'd0, g.raw});
    check("stall_wb",    {7'd0, stall_wb_o},    {7'd0, g.wb});
    check("wb_sel_m",    {7'd0, wb_sel_m_o},    {7'd0, g.sel});
    check("inflight",    {5'd0, inflight_cnt_o}, {5'd0, g.cnt});
    check("drain_ack",   {7'd0, drain_ack_o},   {7'd0, g.ack});
    step++;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rsn_i = 1'b0;
    issue_valid_i = 1'b0; issue_is_m_i = 1'b0; issue_rf_we_i = 1'b0;
    issue_rs1_i = '0; issue_rs2_i = '0; issue_rd_i = '0;
    drain_req_i = 1'b0;
    #3;
    check("rst_inflight",  {5'd0, inflight_cnt_o}, 8'd0);
    check("rst_wb_sel",    {7'd0, wb_sel_m_o},     8'd0);
    check("rst_drain_ack", {7'd0, drain_ack_o},    8'd0);
    check("rst_m_valid",   {7'd0, m_valid_o},      8'd0);
    check("rst_ready",     {7'd0, issue_ready_o},  8'd1);
    @(negedge clk_i);
    rsn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // RAW: MUL x5, dependent ADD waits until the result is written.
    cyc(1,1,1, 1,2,5, 0,  1,1,0,0,0,3'd0,0);
    cyc(1,0,1, 5,0,6, 0,  0,0,1,0,0,3'd1,0);
    cyc(1,0,1, 5,0,6, 0,  0,0,1,1,0,3'd1,0);
    cyc(1,0,1, 5,0,6, 0,  0,0,1,0,0,3'd1,0);
    cyc(1,0,1, 5,0,6, 0,  0,0,1,0,0,3'd1,0);
    cyc(1,0,1, 5,0,6, 0,  0,0,1,0,1,3'd1,0);
    cyc(1,0,1, 5,0,6, 0,  1,0,0,0,0,3'd0,0);

    // Writeback-port conflict: ADD must not land on the MUL writeback cycle.
    cyc(1,1,1, 0,0,7, 0,  1,1,0,0,0,3'd0,0);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd1,0);
    cyc(1,0,1, 0,0,9, 0,  0,0,0,1,0,3'd1,0);
    cyc(1,0,1, 0,0,9, 0,  1,0,0,0,0,3'd1,0);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd1,0);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,1,3'd1,0);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd0,0);

    // Five back-to-back MULs fill the scoreboard, then drain out.
    for (int i = 0; i < 5; i++) begin
      cyc(1,1,1, 0,0,5'(i+1), 0,  1,1,0,0,0,3'(i),0);
    end
    cyc(1,0,0, 1,0,0, 0,  0,0,1,0,1,3'd5,0);
    for (int i = 1; i < 5; i++) begin
      cyc(0,0,0, 0,0,0, 0,  1,0,0,0,1,3'(5-i),0);
    end
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd0,0);

    // Drain with two MULs in flight.
    cyc(1,1,1, 0,0,3, 0,  1,1,0,0,0,3'd0,0);
    cyc(1,1,1, 0,0,4, 0,  1,1,0,0,0,3'd1,0);
    cyc(0,0,0, 0,0,0, 1,  1,0,0,0,0,3'd2,0);
    cyc(1,1,1, 0,0,12,1,  0,0,0,0,0,3'd2,0);
    cyc(0,0,0, 0,0,0, 1,  0,0,0,0,0,3'd2,0);
    cyc(0,0,0, 0,0,0, 1,  0,0,0,0,1,3'd2,0);
    cyc(0,0,0, 0,0,0, 1,  0,0,0,0,1,3'd1,0);
    cyc(0,0,0, 0,0,0, 1,  0,0,0,0,0,3'd0,0);
    cyc(0,0,0, 0,0,0, 1,  0,0,0,0,0,3'd0,1);
    cyc(0,0,0, 0,0,0, 0,  0,0,0,0,0,3'd0,1);
    cyc(1,1,1, 0,0,12,0,  1,1,0,0,0,3'd0,0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0,0,0, 0,0,0, 0,  1,0,0,0,(i == 5),3'd1,0);
    end
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd0,0);

    // Drain request on an empty pipeline goes straight to acknowledged.
    cyc(0,0,0, 0,0,0, 1,  1,0,0,0,0,3'd0,0);
    cyc(0,0,0, 0,0,0, 1,  0,0,0,0,0,3'd0,1);
    cyc(0,0,0, 0,0,0, 0,  0,0,0,0,0,3'd0,1);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd0,0);

    // x0 is never a hazard.
    cyc(1,1,0, 0,0,0, 0,  1,1,0,0,0,3'd0,0);
    cyc(1,0,1, 0,0,0, 0,  1,0,0,0,0,3'd1,0);
    for (int i = 0; i < 4; i++) begin
      cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd1,0);
    end
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd0,0);

    // WAW against a pending MUL, with a cycle where both stalls are raised.
    cyc(1,1,1, 0,0,8, 0,  1,1,0,0,0,3'd0,0);
    cyc(1,0,1, 0,0,8, 0,  0,0,1,0,0,3'd1,0);
    cyc(1,0,1, 0,0,8, 0,  0,0,1,1,0,3'd1,0);
    cyc(1,0,1, 0,0,8, 0,  0,0,1,0,0,3'd1,0);
    cyc(1,0,1, 0,0,8, 0,  0,0,1,0,0,3'd1,0);
    cyc(1,0,1, 0,0,8, 0,  0,0,1,0,1,3'd1,0);
    cyc(1,0,1, 0,0,8, 0,  1,0,0,0,0,3'd0,0);

    // Reset with three slots occupied, one of them at writeback.
    cyc(1,1,1, 0,0,1, 0,  1,1,0,0,0,3'd0,0);
    cyc(1,1,1, 0,0,2, 0,  1,1,0,0,0,3'd1,0);
    cyc(1,1,1, 0,0,3, 0,  1,1,0,0,0,3'd2,0);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd3,0);
    cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd3,0);
    check("pre_rst_inflight", {5'd0, inflight_cnt_o}, 8'd3);
    check("pre_rst_wb_sel",   {7'd0, wb_sel_m_o},     8'd1);
    #1;
    rsn_i = 1'b0;
    #1;
    check("mid_rst_inflight", {5'd0, inflight_cnt_o}, 8'd0);
    check("mid_rst_wb_sel",   {7'd0, wb_sel_m_o},     8'd0);
    @(negedge clk_i);
    rsn_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) begin
      cyc(0,0,0, 0,0,0, 0,  1,0,0,0,0,3'd0,0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
